// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counter encoding
// and its reset / allocation values.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam bp_ctr_t BP_CTR_RESET = WNT;
  localparam bp_ctr_t BP_CTR_ALLOC = WT;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
  import bp_pkg::*;
(
  input  bp_ctr_t ctr_i,
  input  logic    taken_i,
  output bp_ctr_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      SNT: ctr_o = taken_i ? WNT : SNT;
      WNT: ctr_o = taken_i ? WT  : SNT;
      WT:  ctr_o = taken_i ? ST  : WNT;
      ST:  ctr_o = taken_i ? ST  : WT;
      default: ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup from Fetch,
// synchronous training from Execute.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] pcF_i,
  output logic            hit_o,
  output logic            predict_taken_o,
  output logic [XLEN-1:0] predict_target_o,
  output logic [XLEN-1:0] pc_pred_o,
  input  logic            we_i,
  input  logic [XLEN-1:0] pcE_i,
  input  logic            taken_i,
  input  logic [XLEN-1:0] targetE_i
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  bp_ctr_t         ctr_q    [ENTRIES];

  logic [IDX-1:0]  idx_f, idx_e;
  logic [TAGW-1:0] tag_f, tag_e;
  logic            hit_f, hit_e;
  bp_ctr_t         ctr_f, ctr_e, ctr_e_next;
  logic            upd_ctr, upd_tgt, alloc;

  // Byte-offset bits never affect index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pcF_i[1:0], pcE_i[1:0]};

  assign idx_f = pcF_i[IDX+1:2];
  assign tag_f = pcF_i[XLEN-1:IDX+2];
  assign idx_e = pcE_i[IDX+1:2];
  assign tag_e = pcE_i[XLEN-1:IDX+2];

  // Lookup path: reads current flop contents, so a same-cycle update is not seen.
  always_comb begin
    ctr_f            = ctr_q[idx_f];
    hit_f            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    hit_o            = hit_f;
    predict_taken_o  = hit_f & ctr_f[1];
    predict_target_o = hit_f ? target_q[idx_f] : '0;
    pc_pred_o        = predict_taken_o ? predict_target_o : (pcF_i + XLEN'(4));
  end

  always_comb begin
    ctr_e   = ctr_q[idx_e];
    hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    upd_ctr = we_i & hit_e;
    alloc   = we_i & ~hit_e & taken_i;
    upd_tgt = we_i & taken_i;
  end

  sat_counter2 u_sat_counter2 (
    .ctr_i   (ctr_e),
    .taken_i (taken_i),
    .ctr_o   (ctr_e_next)
  );

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    logic sel;
    assign sel = (idx_e == IDX'(g));

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        valid_q[g]  <= 1'b0;
        tag_q[g]    <= '0;
        target_q[g] <= '0;
        ctr_q[g]    <= BP_CTR_RESET;
      end else if (sel) begin
        if (alloc) begin
          valid_q[g] <= 1'b1;
          tag_q[g]   <= tag_e;
          ctr_q[g]   <= BP_CTR_ALLOC;
        end else if (upd_ctr) begin
          ctr_q[g]   <= ctr_e_next;
        end
        // Taken outcomes refresh the target whether hitting or allocating.
        if (upd_tgt) begin
          target_q[g] <= targetE_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: lookups push expectations, a
// negedge checker pops and compares them.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pcF_i;
  logic        hit_o;
  logic        predict_taken_o;
  logic [31:0] predict_target_o;
  logic [31:0] pc_pred_o;
  logic        we_i;
  logic [31:0] pcE_i;
  logic        taken_i;
  logic [31:0] targetE_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] pred;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  branch_predictor #(
    .ENTRIES (16),
    .XLEN    (32)
  ) u_dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .pcF_i            (pcF_i),
    .hit_o            (hit_o),
    .predict_taken_o  (predict_taken_o),
    .predict_target_o (predict_target_o),
    .pc_pred_o        (pc_pred_o),
    .we_i             (we_i),
    .pcE_i            (pcE_i),
    .taken_i          (taken_i),
    .targetE_i        (targetE_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.name, ".hit"},    {31'd0, hit_o},           {31'd0, e.hit});
      check({e.name, ".taken"},  {31'd0, predict_taken_o}, {31'd0, e.taken});
      check({e.name, ".target"}, predict_target_o,          e.tgt);
      check({e.name, ".pc_pred"}, pc_pred_o,                e.pred);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    we_i    = 1'b0;
    reset_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
  endtask

  task automatic set_upd(input logic [31:0] pce, input logic tk, input logic [31:0] tgt);
    we_i      = 1'b1;
    pcE_i     = pce;
    taken_i   = tk;
    targetE_i = tgt;
  endtask

  task automatic upd(input logic [31:0] pce, input logic tk, input logic [31:0] tgt);
    set_upd(pce, tk, tgt);
    tick();
  endtask

  // Expected pc_pred follows directly from the expected prediction.
  task automatic look(input string name, input logic [31:0] pcf, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    exp_t e;
    pcF_i   = pcf;
    e.name  = name;
    e.hit   = hit;
    e.taken = tk;
    e.tgt   = tgt;
    e.pred  = tk ? tgt : pcf + 32'd4;
    sb_q.push_back(e);
    tick();
  endtask

  initial begin
    reset_i   = 1'b1;
    we_i      = 1'b0;
    pcF_i     = '0;
    pcE_i     = '0;
    taken_i   = 1'b0;
    targetE_i = '0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state
    do_reset();
    look("s1", 32'h100, 1'b0, 1'b0, 32'h0);

    // Allocation
    upd(32'h100, 1'b1, 32'h80);
    look("s2", 32'h100, 1'b1, 1'b1, 32'h80);

    // Counter walk down, saturate at SNT, then up to ST
    upd(32'h100, 1'b0, 32'h0);
    look("s3a", 32'h100, 1'b1, 1'b0, 32'h80);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    look("s3b", 32'h100, 1'b1, 1'b0, 32'h80);
    upd(32'h100, 1'b1, 32'h80);
    look("s3c", 32'h100, 1'b1, 1'b0, 32'h80);
    repeat (4) upd(32'h100, 1'b1, 32'h90);
    upd(32'h100, 1'b0, 32'h44);
    look("s3d", 32'h100, 1'b1, 1'b1, 32'h90);
    upd(32'h100, 1'b0, 32'h44);
    look("s3e", 32'h100, 1'b1, 1'b0, 32'h90);

    // Aliasing at index 0
    do_reset();
    upd(32'h140, 1'b0, 32'h200);
    look("s4a", 32'h140, 1'b0, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h80);
    look("s4b", 32'h100, 1'b1, 1'b1, 32'h80);
    look("s4c", 32'h104, 1'b0, 1'b0, 32'h0);
    upd(32'h140, 1'b1, 32'h200);
    look("s4d", 32'h100, 1'b0, 1'b0, 32'h0);
    look("s4e", 32'h140, 1'b1, 1'b1, 32'h200);

    // Same-cycle update and lookup: read-old
    do_reset();
    set_upd(32'h100, 1'b1, 32'h80);
    look("s5a", 32'h100, 1'b0, 1'b0, 32'h0);
    look("s5b", 32'h100, 1'b1, 1'b1, 32'h80);
    look("s5c", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

    // Reset wins over a concurrent update
    set_upd(32'h104, 1'b1, 32'h40);
    do_reset();
    look("s6a", 32'h100, 1'b0, 1'b0, 32'h0);
    look("s6b", 32'h104, 1'b0, 1'b0, 32'h0);

    repeat (2) @(posedge clk_i);
    check("sb_drain", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the five-stage RISC-V pipeline: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. It is looked up combinationally with the Fetch-stage PC to produce the predicted next PC. It is trained from the Execute stage by the controller's `branch_taken_o` / `branch_predictor_we_o` outputs together with the Execute PC and the resolved branch target.

## Interface
- `ENTRIES`, 16: number of BTB entries; power of two, at least 2. `IDX = $clog2(ENTRIES)`.
- `XLEN`, 32: PC / target width.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `pcF_i`  in  XLEN  Fetch-stage PC to look up.
- `hit_o`  out  1  lookup entry is valid and its tag matches `pcF_i`.
- `predict_taken_o`  out  1  `hit_o & counter[1]`.
- `predict_target_o`  out  XLEN  stored target on hit; 0 on miss.
- `pc_pred_o`  out  XLEN  `predict_taken_o ? predict_target_o : pcF_i + 4`.
- `we_i`  in  1  update strobe; driven by `branch_predictor_we_o`.
- `pcE_i`  in  XLEN  PC of the branch resolving in Execute.
- `taken_i`  in  1  resolved outcome; driven by `branch_taken_o`.
- `targetE_i`  in  XLEN  resolved branch target (PCTargetE).

## Operation
- Index = `pc[IDX+1:2]`. Tag = `pc[XLEN-1:IDX+2]`. Bits `[1:0]` are ignored.
- Each entry holds `valid` (1 bit), `tag` (XLEN-IDX-2 bits), `target` (XLEN bits) and `ctr` (2 bits).
- Counter states: SNT=00, WNT=01, WT=10, ST=11. Prediction is taken iff `ctr[1]` is set.
- Update at the rising edge when `we_i=1` and `reset_i=0`, using index and tag taken from `pcE_i`:
  - Hit, taken: `ctr` increments and saturates at ST; `target <= targetE_i`.
  - Hit, not taken: `ctr` decrements and saturates at SNT; `target` is unchanged.
  - Miss (invalid entry or tag mismatch), taken: allocate. `valid<=1`, `tag<=tag(pcE_i)`, `target<=targetE_i`, `ctr<=WT`. Any aliasing entry is overwritten.
  - Miss, not taken: no change; a not-taken branch is never allocated.
- `we_i=0`: the arrays hold their contents.
- `pc_pred_o` addition is XLEN-bit and wraps modulo 2^XLEN; e.g. `0xFFFFFFFC + 4 = 0`.
- Reset, at one rising edge with `reset_i=1`: every `valid<=0`, `ctr<=WNT`, `target<=0`, `tag<=0`. Any update presented in the same cycle is dropped.

## Timing
- Lookup is purely combinational, with 0-cycle latency from `pcF_i` to all outputs. The result must be usable by the PC mux in the same cycle.
- Update has 1-cycle latency: it becomes visible to lookups in the cycle after the edge.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents (read-old).
- Output values after reset, while no update has occurred: `hit_o=0`, `predict_taken_o=0`, `predict_target_o=0`, `pc_pred_o=pcF_i+4`.
- Flushes are not seen by this block. The pipeline gates `we_i` via its ID/EX flush, so a flushed branch never trains the predictor.

## Structure
- Shared package `bp_pkg` contains:
  - `typedef enum logic [1:0] {SNT, WNT, WT, ST} bp_ctr_t;`
  - `localparam bp_ctr_t BP_CTR_RESET = WNT;`
  - `localparam bp_ctr_t BP_CTR_ALLOC = WT;`
- Sub-module `sat_counter2` is a combinational next-state function: inputs `bp_ctr_t` and taken, output the next `bp_ctr_t`.
- Storage is implemented as flop arrays, not inferred RAM, because the block needs a combinational read and a synchronous full reset.

## Test plan
Defaults for all scenarios: `ENTRIES=16`, `XLEN=32`.
1. Reset, then `pcF_i=0x100` -> `hit_o=0`, `predict_taken_o=0`, `predict_target_o=0`, `pc_pred_o=0x104`.
2. One update with `we_i=1`, `pcE_i=0x100`, `taken_i=1`, `targetE_i=0x80`. Next cycle, `pcF_i=0x100` -> `hit_o=1`, `predict_taken_o=1`, `pc_pred_o=0x80`.
3. From scenario 2, apply three not-taken updates to 0x100:
   - After the first (WT->WNT), a lookup gives `predict_taken_o=0`, `pc_pred_o=0x104`, `hit_o=1`.
   - After the third, the counter is held at SNT.
   - Four taken updates then saturate at ST; a single not-taken after that still predicts taken.
4. Aliasing:
   - Not-taken update for 0x140 on a fresh table -> lookup of 0x140 gives `hit_o=0` (no allocation).
   - Taken update for 0x140 with target 0x200 over an entry holding 0x100 -> lookup of 0x100 gives `hit_o=0`; lookup of 0x140 gives `pc_pred_o=0x200`.
5. Same-cycle update (0x100, taken, target 0x80) and lookup of 0x100 on a fresh table -> `hit_o=0` in that cycle, `hit_o=1` the next cycle. Separately, `pcF_i=0xFFFFFFFC` on a miss -> `pc_pred_o=0x0`.
6. Populate 0x100. Assert `reset_i` for one cycle with `we_i=1` (pcE 0x104, taken) -> afterwards, lookups of 0x100 and 0x104 both give `hit_o=0`.
